// File: rtl/traffic_phase_controller.sv
// rtl/traffic_phase_controller.sv - four-approach traffic phase sequencer with walk, pre-emption and flash
// Lamps are registered from the next-state decode so they always match the state register.
module traffic_phase_controller #(
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int PED_CYC    = 6,
  parameter int FLASH_HALF = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req,
  input  logic       emerg,
  input  logic       flash_en,
  output logic [2:0] M1,
  output logic [2:0] MT,
  output logic [2:0] M2,
  output logic [2:0] S,
  output logic       walk,
  output logic       ped_pending,
  output logic [3:0] phase
);

  typedef enum logic [3:0] {
    AR = 4'd0, G0 = 4'd1, Y0 = 4'd2, G1 = 4'd3, Y1 = 4'd4, G2 = 4'd5,
    Y2 = 4'd6, WALK = 4'd7, EY = 4'd8, ER = 4'd9, FLASH = 4'd10
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_HALF - 1);

  state_t           state, nxt_state, ar_exit;
  logic [CNT_W-1:0] count, nxt_count;
  logic [3:0]       emask, nxt_emask;
  logic             blink, nxt_blink, nxt_ped;
  logic [12:0]      lamps_q;

  function automatic logic [12:0] decode(input state_t s, input logic [3:0] em, input logic bl);
    case (s)
      G0:      decode = {GRN, RED, GRN, RED, 1'b0};
      Y0:      decode = {GRN, RED, YEL, RED, 1'b0};
      G1:      decode = {GRN, GRN, RED, RED, 1'b0};
      Y1:      decode = {YEL, YEL, RED, RED, 1'b0};
      G2:      decode = {RED, RED, RED, GRN, 1'b0};
      Y2:      decode = {RED, RED, RED, YEL, 1'b0};
      WALK:    decode = {RED, RED, RED, RED, 1'b1};
      EY:      decode = {em[3] ? YEL : RED, em[2] ? YEL : RED,
                         em[1] ? YEL : RED, em[0] ? YEL : RED, 1'b0};
      FLASH:   decode = {bl ? YEL : OFF, bl ? YEL : OFF, bl ? YEL : OFF, bl ? YEL : OFF, 1'b0};
      default: decode = {RED, RED, RED, RED, 1'b0};
    endcase
  endfunction

  assign {M1, MT, M2, S, walk} = lamps_q;
  assign phase = state;

  always_comb begin
    ar_exit = flash_en ? FLASH : (ped_pending ? WALK : G0);
  end

  always_comb begin
    nxt_state = state;
    nxt_emask = emask;
    nxt_blink = blink;
    case (state)
      AR:    if (emerg) nxt_state = ER;
             else if (count == ALLRED_LAST) nxt_state = ar_exit;
      G0, G1, G2: begin
        if (emerg) nxt_state = EY;
        else if (count == GREEN_LAST) nxt_state = state_t'(state + 4'd1);
      end
      Y0, Y1, Y2: begin
        if (emerg) nxt_state = EY;
        else if (count == YELLOW_LAST) nxt_state = (state == Y2) ? AR : state_t'(state + 4'd1);
      end
      WALK:  if (emerg) nxt_state = ER;
             else if (count == PED_LAST) nxt_state = G0;
      EY:    if (count == YELLOW_LAST) nxt_state = ER;
      ER:    if (!emerg && count >= ALLRED_LAST) nxt_state = ar_exit;
      FLASH: begin
        if (emerg) nxt_state = ER;
        else if (!flash_en) nxt_state = AR;
        else if (count == FLASH_LAST) nxt_blink = ~blink;
      end
      default: nxt_state = AR;
    endcase

    // Approaches lit green or yellow right now are the ones that get a yellow in EY.
    if (nxt_state == EY && state != EY)
      nxt_emask = {|M1[1:0], |MT[1:0], |M2[1:0], |S[1:0]};
    if (nxt_state == FLASH && state != FLASH)
      nxt_blink = 1'b1;

    if (nxt_state != state)
      nxt_count = '0;
    else if (state == FLASH && count == FLASH_LAST)
      nxt_count = '0;
    else if (state == ER && (&count))
      nxt_count = count;
    else
      nxt_count = count + 1'b1;

    nxt_ped = ped_req | (ped_pending & ~(nxt_state == WALK && state != WALK));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= AR;
      count       <= '0;
      emask       <= '0;
      blink       <= 1'b0;
      ped_pending <= 1'b0;
      lamps_q     <= {RED, RED, RED, RED, 1'b0};
    end else begin
      state       <= nxt_state;
      count       <= nxt_count;
      emask       <= nxt_emask;
      blink       <= nxt_blink;
      ped_pending <= nxt_ped;
      lamps_q     <= decode(nxt_state, nxt_emask, nxt_blink);
    end
  end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb/tb_traffic_phase_controller.sv - scoreboard bench for traffic_phase_controller
module tb_traffic_phase_controller;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] D = 3'b000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ped_req = 1'b0;
  logic emerg = 1'b0;
  logic flash_en = 1'b0;
  logic [2:0] M1, MT, M2, S;
  logic walk, ped_pending;
  logic [3:0] phase;

  int n_vec = 0;
  int n_miss = 0;
  int k = 0;

  typedef struct packed {
    logic [3:0]  ph;
    logic [12:0] lamps;
  } exp_t;
  exp_t sb_q[$];

  traffic_phase_controller dut (
    .clk(clk), .rst(rst), .ped_req(ped_req), .emerg(emerg), .flash_en(flash_en),
    .M1(M1), .MT(MT), .M2(M2), .S(S), .walk(walk), .ped_pending(ped_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] lamp_of(input int ph, input logic [3:0] em, input logic bl);
    case (ph)
      1:  return {G, R, G, R, 1'b0};
      2:  return {G, R, Y, R, 1'b0};
      3:  return {G, G, R, R, 1'b0};
      4:  return {Y, Y, R, R, 1'b0};
      5:  return {R, R, R, G, 1'b0};
      6:  return {R, R, R, Y, 1'b0};
      7:  return {R, R, R, R, 1'b1};
      8:  return {em[3] ? Y : R, em[2] ? Y : R, em[1] ? Y : R, em[0] ? Y : R, 1'b0};
      10: return bl ? {Y, Y, Y, Y, 1'b0} : {D, D, D, D, 1'b0};
      default: return {R, R, R, R, 1'b0};
    endcase
  endfunction

  task automatic push(input int ph, input int n, input logic [3:0] em = 4'b0, input logic bl = 1'b0);
    exp_t e;
    e.ph = 4'(ph);
    e.lamps = lamp_of(ph, em, bl);
    repeat (n) sb_q.push_back(e);
  endtask

  task automatic push_main();
    push(1, 8); push(2, 3); push(3, 8); push(4, 3); push(5, 8); push(6, 3);
  endtask

  task automatic check_now();
    exp_t e;
    check_val($sformatf("sb_nonempty@%0d", k), 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val($sformatf("phase@%0d", k), 32'(phase), 32'(e.ph));
      check_val($sformatf("lamps@%0d", k), 32'({M1, MT, M2, S, walk}), 32'(e.lamps));
    end
  endtask

  initial begin
    ped_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_phase", 32'(phase), 32'd0);
    check_val("rst_lamps", 32'({M1, MT, M2, S, walk}), 32'({R, R, R, R, 1'b0}));
    check_val("rst_pending", 32'(ped_pending), 32'd0);
    ped_req = 1'b0;
    rst = 1'b1;

    push(0, 2); push_main();
    push(0, 2); push_main();
    push(0, 2); push(7, 6); push_main();
    push(0, 2); push(7, 6); push(1, 8); push(2, 3); push(3, 4); push(8, 3, 4'b1100); push(9, 7);
    push_main();
    push(0, 2); push(7, 2); push(9, 2);
    push_main();
    push(0, 2);
    push(10, 4, 4'b0, 1'b1); push(10, 4, 4'b0, 1'b0); push(10, 4, 4'b0, 1'b1);
    push(10, 4, 4'b0, 1'b0); push(10, 2, 4'b0, 1'b1);
    push(9, 2);
    push(10, 4, 4'b0, 1'b1); push(10, 2, 4'b0, 1'b0);
    push(0, 2); push(1, 8); push(2, 3); push(3, 8); push(4, 2);

    k = 0;
    check_now();
    for (k = 1; k <= 266; k++) begin
      @(posedge clk);
      #1;
      check_now();
      case (k)
        50:  ped_req = 1'b1;
        51:  begin ped_req = 1'b0; check_val("pend_set", 32'(ped_pending), 32'd1); end
        71:  check_val("pend_held_ar", 32'(ped_pending), 32'd1);
        72:  check_val("pend_clr_walk", 32'(ped_pending), 32'd0);
        73:  ped_req = 1'b1;
        74:  begin ped_req = 1'b0; check_val("pend_in_walk", 32'(ped_pending), 32'd1); end
        113: check_val("pend_clr_walk2", 32'(ped_pending), 32'd0);
        133: emerg = 1'b1;
        143: emerg = 1'b0;
        160: ped_req = 1'b1;
        161: begin ped_req = 1'b0; check_val("pend_set2", 32'(ped_pending), 32'd1); end
        179: check_val("pend_clr_walk3", 32'(ped_pending), 32'd0);
        180: emerg = 1'b1;
        181: emerg = 1'b0;
        207: flash_en = 1'b1;
        235: emerg = 1'b1;
        236: emerg = 1'b0;
        243: flash_en = 1'b0;
        default: ;
      endcase
    end

    #3 rst = 1'b0;
    #1;
    check_val("async_rst_phase", 32'(phase), 32'd0);
    check_val("async_rst_lamps", 32'({M1, MT, M2, S, walk}), 32'({R, R, R, R, 1'b0}));
    repeat (2) @(posedge clk);
    #1;
    check_val("held_rst_phase", 32'(phase), 32'd0);
    rst = 1'b1;
    push(0, 2); push(1, 8); push(2, 1);
    k = 300;
    check_now();
    for (k = 301; k <= 310; k++) begin
      @(posedge clk);
      #1;
      check_now();
    end
    check_val("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
